// File: rtl/instr_stream_encoder_if.sv
// Host/instruction-memory bundle for instr_stream_encoder.
// The host drives one symbolic instruction per handshake and observes the memory write port and status.
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              last;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;
  logic              cpu_hold;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target, last,
    input  in_ready, im_we, im_addr, im_wdata, count, done, err, cpu_hold
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target, last,
    output in_ready, im_we, im_addr, im_wdata, count, done, err, cpu_hold
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and writes them to consecutive instruction-memory words.
// Optional feature macro ENC_NOP_PAD_EN: append one NOP word after the last instruction.
module instr_stream_encoder #(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_stream_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
`ifdef ENC_NOP_PAD_EN
    S_PAD   = 3'd2,
`endif
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  function automatic logic is_legal(input logic [4:0] m);
    return (m <= 5'd21);
  endfunction

  function automatic logic [31:0] encode(
    input logic [4:0]  m,
    input logic [4:0]  rs_f,
    input logic [4:0]  rt_f,
    input logic [4:0]  rd_f,
    input logic [4:0]  sh_f,
    input logic [15:0] imm_f,
    input logic [25:0] tgt_f
  );
    logic [5:0]  funct;
    logic [5:0]  op;
    logic [31:0] w;
    funct = 6'h00;
    op    = 6'h00;
    w     = 32'h0000_0000;
    case (m)
      5'd0:    funct = 6'h20;
      5'd1:    funct = 6'h21;
      5'd2:    funct = 6'h22;
      5'd3:    funct = 6'h23;
      5'd4:    funct = 6'h24;
      5'd5:    funct = 6'h25;
      5'd6:    funct = 6'h26;
      5'd7:    funct = 6'h27;
      5'd8:    funct = 6'h2A;
      5'd9:    funct = 6'h2B;
      5'd10:   funct = 6'h00;
      5'd11:   funct = 6'h02;
      5'd12:   funct = 6'h03;
      5'd13:   funct = 6'h04;
      5'd14:   funct = 6'h06;
      5'd15:   funct = 6'h07;
      default: funct = 6'h00;
    endcase
    case (m)
      5'd16:   op = 6'h08;
      5'd17:   op = 6'h04;
      5'd18:   op = 6'h2B;
      5'd19:   op = 6'h23;
      5'd20:   op = 6'h02;
      5'd21:   op = 6'h03;
      default: op = 6'h00;
    endcase
    // Immediate shifts carry the amount in shamt, so rs is zeroed; variable shifts and ALU ops zero shamt.
    if (m <= 5'd15) begin
      if ((m >= 5'd10) && (m <= 5'd12)) begin
        w = {6'h00, 5'd0, rt_f, rd_f, sh_f, funct};
      end else begin
        w = {6'h00, rs_f, rt_f, rd_f, 5'd0, funct};
      end
    end else if (m <= 5'd19) begin
      w = {op, rs_f, rt_f, imm_f};
    end else if (m <= 5'd21) begin
      w = {op, tgt_f};
    end else begin
      w = 32'h0000_0000;
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              last_q, last_d;

  logic              hs_s;
  logic              addr_at_last_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic [ADDR_W:0]   count_inc_s;

  assign hs_s           = bus.in_valid & in_ready_q;
  assign addr_at_last_s = (im_addr_q == ADDR_LAST);
  assign addr_next_s    = addr_at_last_s ? im_addr_q : (im_addr_q + ADDR_ONE);
  assign count_inc_s    = (count_q == COUNT_MAX) ? count_q : (count_q + COUNT_ONE);

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    count_d    = count_q;
    done_d     = done_q;
    err_d      = err_q;
    cpu_hold_d = cpu_hold_q;
    last_d     = last_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (hs_s) begin
          in_ready_d = 1'b0;
          if (is_legal(bus.mnem)) begin
            im_wdata_d = encode(bus.mnem, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm, bus.target);
            last_d     = bus.last;
            im_we_d    = 1'b1;
            state_d    = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        count_d    = count_inc_s;
        in_ready_d = 1'b0;
        if (last_q) begin
`ifdef ENC_NOP_PAD_EN
          // The NOP is only issued if a free word remains; PAD faults otherwise.
          state_d    = S_PAD;
          im_wdata_d = 32'h0000_0000;
          if (!addr_at_last_s) begin
            im_addr_d = addr_next_s;
            im_we_d   = 1'b1;
          end else begin
            im_we_d = 1'b0;
          end
`else
          im_addr_d  = addr_next_s;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
          state_d    = S_DONE;
`endif
        end else if (addr_at_last_s) begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end else begin
          im_addr_d  = addr_next_s;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

`ifdef ENC_NOP_PAD_EN
      S_PAD: begin
        in_ready_d = 1'b0;
        if (im_we_q) begin
          count_d    = count_inc_s;
          im_addr_d  = addr_next_s;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end
      end
`endif

      S_DONE: begin
        in_ready_d = 1'b0;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        state_d    = S_DONE;
      end

      S_FAULT: begin
        in_ready_d = 1'b0;
        err_d      = 1'b1;
        done_d     = 1'b0;
        cpu_hold_d = 1'b1;
        state_d    = S_FAULT;
      end

      default: begin
        in_ready_d = 1'b0;
        err_d      = 1'b1;
        done_d     = 1'b0;
        cpu_hold_d = 1'b1;
        state_d    = S_FAULT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b1;
      im_we_q    <= 1'b0;
      im_addr_q  <= ADDR_BASE;
      im_wdata_q <= 32'h0000_0000;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
      last_q     <= last_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign bus.count    = count_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: a 1024-word instance and a 4-word instance for overflow.
module tb_instr_stream_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v_a = 1'b0;
  logic        v_b = 1'b0;
  logic [4:0]  t_mnem = 5'd0, t_rs = 5'd0, t_rt = 5'd0, t_rd = 5'd0, t_sh = 5'd0;
  logic [15:0] t_imm = 16'h0;
  logic [25:0] t_tgt = 26'h0;
  logic        t_last = 1'b0;

  instr_stream_encoder_if #(.ADDR_W(10)) ifa ();
  instr_stream_encoder_if #(.ADDR_W(2))  ifb ();

  assign ifa.in_valid = v_a;
  assign ifa.mnem = t_mnem;  assign ifa.rs = t_rs;  assign ifa.rt = t_rt;  assign ifa.rd = t_rd;
  assign ifa.shamt = t_sh;   assign ifa.imm = t_imm; assign ifa.target = t_tgt; assign ifa.last = t_last;
  assign ifb.in_valid = v_b;
  assign ifb.mnem = t_mnem;  assign ifb.rs = t_rs;  assign ifb.rt = t_rt;  assign ifb.rd = t_rd;
  assign ifb.shamt = t_sh;   assign ifb.imm = t_imm; assign ifb.target = t_tgt; assign ifb.last = t_last;

  instr_stream_encoder #(.ADDR_W(10), .BASE(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  instr_stream_encoder #(.ADDR_W(2),  .BASE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_pass = 0;
  int n_total = 0;
  int exp_addr_a = 0;
  int exp_addr_b = 0;
  logic [41:0] q_a[$];
  logic [41:0] q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the large instance: every write must match the head of its queue.
  always @(negedge clk) begin : mon_a
    logic [41:0] e;
    if (ifa.im_we === 1'b1) begin
      if (q_a.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_write: got write addr 0x%0h data 0x%0h, expected no write", ifa.im_addr, ifa.im_wdata);
      end else begin
        e = q_a.pop_front();
        chk("a_addr", 64'(ifa.im_addr), 64'(e[41:32]));
        chk("a_data", 64'(ifa.im_wdata), 64'(e[31:0]));
        chk("a_ready_excl", 64'(ifa.in_ready), 64'd0);
      end
    end
  end

  // Monitor for the small instance.
  always @(negedge clk) begin : mon_b
    logic [41:0] e;
    if (ifb.im_we === 1'b1) begin
      if (q_b.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_write: got write addr 0x%0h data 0x%0h, expected no write", ifb.im_addr, ifb.im_wdata);
      end else begin
        e = q_b.pop_front();
        chk("b_addr", 64'(ifb.im_addr), 64'(e[41:32]));
        chk("b_data", 64'(ifb.im_wdata), 64'(e[31:0]));
        chk("b_ready_excl", 64'(ifb.in_ready), 64'd0);
      end
    end
  end

  // Present one instruction, wait (bounded) for the handshake, push the expected write if legal.
  task automatic send(input bit to_b, input logic [4:0] m, input logic [4:0] rs_i, input logic [4:0] rt_i,
                      input logic [4:0] rd_i, input logic [4:0] sh_i, input logic [15:0] imm_i,
                      input logic [25:0] tgt_i, input bit lst, input bit legal, input logic [31:0] word);
    bit rdy;
    rdy = 1'b0;
    t_mnem = m; t_rs = rs_i; t_rt = rt_i; t_rd = rd_i; t_sh = sh_i;
    t_imm = imm_i; t_tgt = tgt_i; t_last = lst;
    if (to_b) v_b = 1'b1; else v_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rdy = to_b ? ifb.in_ready : ifa.in_ready;
      if (rdy) break;
      @(posedge clk); #1;
    end
    if (!rdy) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 16 cycles");
    end else begin
      @(posedge clk);
      if (legal) begin
        if (to_b) begin q_b.push_back({10'(exp_addr_b), word}); exp_addr_b++; end
        else      begin q_a.push_back({10'(exp_addr_a), word}); exp_addr_a++; end
      end
      #1;
    end
  endtask

  task automatic do_reset();
    v_a = 1'b0; v_b = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_a_drained", 64'(q_a.size()), 64'd0);
    chk("sb_b_drained", 64'(q_b.size()), 64'd0);
    q_a.delete(); q_b.delete();
    exp_addr_a = 0; exp_addr_b = 0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    chk("rst_im_we",    64'(ifa.im_we),    64'd0);
    chk("rst_im_addr",  64'(ifa.im_addr),  64'd0);
    chk("rst_im_wdata", 64'(ifa.im_wdata), 64'd0);
    chk("rst_count",    64'(ifa.count),    64'd0);
    chk("rst_done",     64'(ifa.done),     64'd0);
    chk("rst_err",      64'(ifa.err),      64'd0);
    chk("rst_cpu_hold", 64'(ifa.cpu_hold), 64'd1);
    rst = 1'b0;

    // Single ADD: write one cycle after handshake.
    send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1820);
    v_a = 1'b0;
    chk("add_we_next_cycle", 64'(ifa.im_we), 64'd1);
    chk("add_ready_low", 64'(ifa.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("add_count", 64'(ifa.count), 64'd1);
    chk("add_ready_back", 64'(ifa.in_ready), 64'd1);
    chk("add_addr_next", 64'(ifa.im_addr), 64'd1);

    // I-type stream with in_valid held high; rd/shamt on ADDI must be ignored.
    do_reset();
    send(1'b0, 5'd16, 5'd0, 5'd2, 5'd31, 5'd7, 16'h0005, 26'h0, 1'b0, 1'b1, 32'h2002_0005);
    send(1'b0, 5'd19, 5'd1, 5'd4, 5'd0,  5'd0, 16'h0008, 26'h0, 1'b0, 1'b1, 32'h8C24_0008);
    send(1'b0, 5'd18, 5'd1, 5'd4, 5'd0,  5'd0, 16'h000C, 26'h0, 1'b0, 1'b1, 32'hAC24_000C);
    send(1'b0, 5'd17, 5'd1, 5'd2, 5'd0,  5'd0, 16'hFFFF, 26'h0, 1'b1, 1'b1, 32'h1022_FFFF);
    v_a = 1'b0;
`ifdef ENC_NOP_PAD_EN
    q_a.push_back({10'd4, 32'h0000_0000});
`endif
    chk("stream_ready_low", 64'(ifa.in_ready), 64'd0);
    @(posedge clk); #1;
`ifdef ENC_NOP_PAD_EN
    chk("pad_done_late", 64'(ifa.done), 64'd0);
    chk("pad_count_pre", 64'(ifa.count), 64'd4);
    @(posedge clk); #1;
    chk("stream_count", 64'(ifa.count), 64'd5);
`else
    chk("stream_count", 64'(ifa.count), 64'd4);
`endif
    chk("stream_done", 64'(ifa.done), 64'd1);
    chk("stream_cpu_hold", 64'(ifa.cpu_hold), 64'd0);
    chk("stream_err", 64'(ifa.err), 64'd0);
    chk("stream_ready_done", 64'(ifa.in_ready), 64'd0);
    t_mnem = 5'd0; v_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_ignores_valid", 64'(ifa.in_ready), 64'd0);
    chk("done_sticky", 64'(ifa.done), 64'd1);
    v_a = 1'b0;

    // Shift/variable-shift field forcing and J-type.
    do_reset();
    send(1'b0, 5'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0001_1100);
    send(1'b0, 5'd15, 5'd3, 5'd4, 5'd5, 5'd9, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0064_2807);
    send(1'b0, 5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, 1'b0, 1'b1, 32'h0810_0000);
    send(1'b0, 5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, 1'b1, 1'b1, 32'h0C10_0000);
    v_a = 1'b0;
`ifdef ENC_NOP_PAD_EN
    q_a.push_back({10'd4, 32'h0000_0000});
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("jtype_done", 64'(ifa.done), 64'd1);

    // Illegal mnemonic: no write, sticky error, further valids ignored.
    do_reset();
    send(1'b0, 5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
    chk("illegal_err", 64'(ifa.err), 64'd1);
    chk("illegal_ready", 64'(ifa.in_ready), 64'd0);
    chk("illegal_hold", 64'(ifa.cpu_hold), 64'd1);
    chk("illegal_done", 64'(ifa.done), 64'd0);
    chk("illegal_no_we", 64'(ifa.im_we), 64'd0);
    t_mnem = 5'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("fault_ready_stays_low", 64'(ifa.in_ready), 64'd0);
    chk("fault_count", 64'(ifa.count), 64'd0);
    v_a = 1'b0;

    // Reset during the WRITE cycle.
    do_reset();
    send(1'b0, 5'd5, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00A6_3825);
    rst = 1'b1; v_a = 1'b0;
    @(posedge clk); #1;
    chk("midrst_we", 64'(ifa.im_we), 64'd0);
    chk("midrst_count", 64'(ifa.count), 64'd0);
    chk("midrst_addr", 64'(ifa.im_addr), 64'd0);
    chk("midrst_ready", 64'(ifa.in_ready), 64'd1);
    chk("midrst_wdata", 64'(ifa.im_wdata), 64'd0);
    rst = 1'b0;

    // Overflow on the 4-word instance.
    do_reset();
    send(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1820);
    send(1'b1, 5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1822);
    send(1'b1, 5'd4, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0085_3024);
    send(1'b1, 5'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_182A);
    t_mnem = 5'd1; t_rd = 5'd9;
    @(posedge clk); #1;
    chk("ovf_err", 64'(ifb.err), 64'd1);
    chk("ovf_ready", 64'(ifb.in_ready), 64'd0);
    chk("ovf_hold", 64'(ifb.cpu_hold), 64'd1);
    chk("ovf_done", 64'(ifb.done), 64'd0);
    chk("ovf_count", 64'(ifb.count), 64'd4);
    chk("ovf_addr_no_wrap", 64'(ifb.im_addr), 64'd3);
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_fifth_refused", 64'(ifb.in_ready), 64'd0);
    chk("ovf_count_stays", 64'(ifb.count), 64'd4);
    v_b = 1'b0;

    @(posedge clk); #1;
    chk("final_a_drained", 64'(q_a.size()), 64'd0);
    chk("final_b_drained", 64'(q_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
